// File: rtl/operand_entry_if.sv
// Keypad operand entry: key inputs and operand/status outputs.
// master drives keys and observes results; slave is the entry unit.
interface operand_entry_if;
    logic       KeyValid;
    logic [3:0] KeyCode;
    logic [7:0] Data1;
    logic [7:0] Data2;
    logic       Ready;
    logic       Error;
    logic [1:0] Phase;

    modport master (
        output KeyValid, KeyCode,
        input  Data1, Data2, Ready, Error, Phase
    );

    modport slave (
        input  KeyValid, KeyCode,
        output Data1, Data2, Ready, Error, Phase
    );
endinterface

// File: rtl/operand_entry.sv
// Keypad operand entry: collects two decimal operands for the adder stage.
// Optional macro OPERAND_SATURATE_EN clamps overflowing operands to 255.
module operand_entry #(
    parameter int MAX_DIGITS = 3
) (
    input  logic      Clk,
    input  logic      Clear,
    operand_entry_if.slave bus
);

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        DONE    = 2'b10
    } phase_t;

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    phase_t        state, state_n;
    logic [7:0]    data1, data1_n;
    logic [7:0]    data2, data2_n;
    logic          err, err_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          kv_q;

    logic          key_event;
    logic          is_digit, is_enter, is_cancel;
    logic [7:0]    acc;
    logic [11:0]   sum;
    logic          ovf;
    logic [7:0]    stored;

    assign key_event = bus.KeyValid & ~kv_q;
    assign is_digit  = bus.KeyCode <= 4'd9;
    assign is_enter  = bus.KeyCode == 4'hA;
    assign is_cancel = bus.KeyCode == 4'hC;

    // Next digit value of the active operand, widened to catch overflow.
    always_comb begin
        acc = (state == ENTER_B) ? data2 : data1;
        sum = {4'd0, acc} * 12'd10 + {8'd0, bus.KeyCode};
        ovf = sum > 12'd255;
`ifdef OPERAND_SATURATE_EN
        stored = ovf ? 8'hFF : sum[7:0];
`else
        stored = sum[7:0];
`endif
    end

    // Edge detector on KeyValid; held high out of reset so a held key is not an event.
    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) kv_q <= 1'b1;
        else        kv_q <= bus.KeyValid;
    end

    // State and operand registers.
    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            state <= ENTER_A;
            data1 <= 8'd0;
            data2 <= 8'd0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            data1 <= data1_n;
            data2 <= data2_n;
            err   <= err_n;
            cnt   <= cnt_n;
        end
    end

    // Key event handling: cancel, enter, digit; other codes fall through.
    always_comb begin
        state_n = state;
        data1_n = data1;
        data2_n = data2;
        err_n   = err;
        cnt_n   = cnt;
        if (key_event) begin
            unique case (1'b1)
                is_cancel: begin
                    state_n = ENTER_A;
                    data1_n = 8'd0;
                    data2_n = 8'd0;
                    err_n   = 1'b0;
                    cnt_n   = '0;
                end
                is_enter: begin
                    unique case (state)
                        ENTER_A: begin
                            state_n = ENTER_B;
                            data2_n = 8'd0;
                            cnt_n   = '0;
                        end
                        ENTER_B: begin
                            state_n = DONE;
                            cnt_n   = '0;
                        end
                        default: ;
                    endcase
                end
                is_digit: begin
                    if (state == DONE) begin
                        state_n = ENTER_A;
                        data1_n = {4'd0, bus.KeyCode};
                        data2_n = 8'd0;
                        err_n   = 1'b0;
                        cnt_n   = CNT_ONE;
                    end else if (cnt < CNT_MAX) begin
                        if (state == ENTER_B) data2_n = stored;
                        else                  data1_n = stored;
                        err_n = err | ovf;
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Data1 = data1;
    assign bus.Data2 = data2;
    assign bus.Error = err;
    assign bus.Ready = state == DONE;
    assign bus.Phase = state;

endmodule

// File: tb/tb_operand_entry.sv
// Randomized bench for operand_entry against a behavioural keypad model.
// Honours OPERAND_SATURATE_EN the same way as the design build.
module tb_operand_entry;

    localparam int MAXD = 3;
`ifdef OPERAND_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic clear;

    operand_entry_if ki ();

    operand_entry #(.MAX_DIGITS(MAXD)) dut (
        .Clk   (clk),
        .Clear (clear),
        .bus   (ki.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int ma, mb, mcnt, mph;
    int merr;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        ma = 0; mb = 0; mcnt = 0; mph = 0; merr = 0;
    endtask

    task automatic model_key(input int code);
        int v;
        if (code == 12) begin
            model_reset();
        end else if (code == 10) begin
            if (mph == 0) begin
                mph = 1; mcnt = 0; mb = 0;
            end else if (mph == 1) begin
                mph = 2;
            end
        end else if (code <= 9) begin
            if (mph == 2) begin
                ma = code; mb = 0; merr = 0; mcnt = 1; mph = 0;
            end else if (mcnt < MAXD) begin
                v = (mph == 0 ? ma : mb) * 10 + code;
                if (v > 255) begin
                    merr = 1;
                    v = SAT ? 255 : v % 256;
                end
                if (mph == 0) ma = v;
                else          mb = v;
                mcnt++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".d1"}, int'(ki.Data1), ma);
        check({tag, ".d2"}, int'(ki.Data2), mb);
        check({tag, ".rdy"}, int'(ki.Ready), (mph == 2) ? 1 : 0);
        check({tag, ".err"}, int'(ki.Error), merr);
        check({tag, ".ph"}, int'(ki.Phase), mph);
    endtask

    // One key press held for 'hold' edges, then released for one edge.
    task automatic press(input int code, input int hold, input string tag);
        @(negedge clk);
        ki.KeyValid = 1'b1;
        ki.KeyCode  = 4'(code);
        model_key(code);
        repeat (hold) @(negedge clk);
        check_all(tag);
        ki.KeyValid = 1'b0;
    endtask

    initial begin
        int r, code;
        ki.KeyValid = 1'b0;
        ki.KeyCode  = 4'd0;
        clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk);
        clear = 1'b1;

        // Two operands and completion.
        press(1, 1, "a1"); press(2, 1, "a2"); press(10, 1, "entA");
        check("entA.ph", int'(ki.Phase), 1);
        press(3, 1, "b3"); press(4, 1, "b4"); press(10, 1, "entB");
        check("done.d1", int'(ki.Data1), 12);
        check("done.d2", int'(ki.Data2), 34);
        check("done.ph", int'(ki.Phase), 2);
        press(10, 1, "done_ent");

        // Digit in DONE restarts; cancel mid-entry clears all.
        press(5, 1, "restart");
        check("restart.d1", int'(ki.Data1), 5);
        press(6, 1, "a6");
        press(12, 1, "cancel");
        check("cancel.d1", int'(ki.Data1), 0);

        // Held key yields one event.
        @(negedge clk);
        ki.KeyValid = 1'b1;
        ki.KeyCode  = 4'd7;
        model_key(7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("held.d1", int'(ki.Data1), 7);
        end
        ki.KeyValid = 1'b0;
        press(12, 1, "c2");

        // Overflow 256 and extra digit ignored.
        press(2, 1, "o2"); press(5, 1, "o5"); press(6, 1, "o6");
        check("ovf.d1", int'(ki.Data1), SAT ? 255 : 0);
        check("ovf.err", int'(ki.Error), 1);
        press(9, 1, "o9");
        press(12, 1, "c3");

        // 9999 Enter.
        for (int i = 0; i < 4; i++) press(9, 1, "n9");
        press(10, 1, "n9ent");
        check("n9.d1", int'(ki.Data1), SAT ? 255 : 231);
        check("n9.ph", int'(ki.Phase), 1);

        // Ignored codes.
        press(11, 1, "ign_b"); press(13, 2, "ign_d");
        press(14, 1, "ign_e"); press(15, 1, "ign_f");

        // Reset during ENTER_B with KeyValid held.
        press(12, 1, "c4"); press(1, 1, "r1"); press(10, 1, "rent");
        @(negedge clk);
        ki.KeyValid = 1'b1;
        ki.KeyCode  = 4'd3;
        model_key(3);
        @(negedge clk);
        check_all("pre_rst");
        clear = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk);
        clear = 1'b1;
        repeat (3) @(negedge clk);
        check_all("held_rst");
        ki.KeyValid = 1'b0;
        press(4, 1, "post_rst");

        // Randomized key stream.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      code = $urandom_range(0, 9);
            else if (r < 77) code = 10;
            else if (r < 83) code = 12;
            else begin
                code = $urandom_range(0, 3);
                code = (code == 0) ? 11 : 12 + code;
            end
            press(code, $urandom_range(1, 3), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 3, meaning the maximum number of decimal digits accepted per operand.
REQ-002 SHALL have port Clk  input  1  rising-edge system clock.
REQ-003 SHALL have port Clear  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port KeyValid  input  1  key-pressed level, synchronous to Clk.
REQ-005 SHALL have port KeyCode  input  4  key code: 0-9 digit, 0xA Enter, 0xC Cancel, others ignored.
REQ-006 SHALL have port Data1  output  8  first operand, unsigned, fed directly to the adder stage.
REQ-007 SHALL have port Data2  output  8  second operand, unsigned, fed directly to the adder stage.
REQ-008 SHALL have port Ready  output  1  high while both operands are complete (state DONE).
REQ-009 SHALL have port Error  output  1  sticky overflow flag.
REQ-010 SHALL have port Phase  output  2  state code: 00 ENTER_A, 01 ENTER_B, 10 DONE.

Function
REQ-011 SHALL detect a key event when KeyValid is sampled 1 at a Clk edge and was sampled 0 at the previous edge; KeyCode SHALL be sampled at the same edge; a held key SHALL yield exactly one event.
REQ-012 SHALL make every effect of a key event visible immediately after the detecting edge (latency one clock, no further pipelining).
REQ-013 SHALL update the active accumulator on a digit event as acc*10 + digit, computed at 12-bit width.
REQ-014 SHALL set Error when the 12-bit result exceeds 255; the stored value SHALL follow REQ-026/REQ-027.
REQ-015 SHALL count digits per operand and ignore digit events once MAX_DIGITS digits have been accepted; ignored digits SHALL NOT change the count or Error.
REQ-016 SHALL, in ENTER_A, route digits to Data1; on Enter it SHALL go to ENTER_B with the digit count set to 0.
REQ-017 SHALL, in ENTER_B, route digits to Data2; on Enter it SHALL go to DONE.
REQ-018 SHALL, on Enter with zero digits accepted, accept the operand as 0.
REQ-019 SHALL, in DONE, hold Data1, Data2 and Ready=1 and ignore Enter.
REQ-020 SHALL, on a digit in DONE, clear Data2 and Error, load Data1 with that digit, set the count to 1 and go to ENTER_A, all at one edge.
REQ-021 SHALL, on Cancel in any state, clear Data1, Data2, Error and the count and go to ENTER_A.
REQ-022 SHALL ignore key codes 0xB and 0xD-0xF in all states.

Reset
REQ-023 SHALL, on Clear low, asynchronously force Data1=0, Data2=0, Ready=0, Error=0, Phase=00 and the digit count to 0.
REQ-024 SHALL reset the previous-KeyValid register to 1, so a key held through reset release produces no event.
REQ-025 SHALL abandon a partially entered operand when reset occurs mid-entry; no value SHALL be retained.

Configuration
REQ-026 SHALL, when the macro OPERAND_SATURATE_EN is defined, clamp an overflowing operand to 255.
REQ-027 SHALL, when OPERAND_SATURATE_EN is undefined, store the low 8 bits of the 12-bit result (wrap modulo 256); Error SHALL set identically in both builds.

Verification
REQ-028 SHALL cover: keys 1,2,Enter,3,4,Enter -> Data1=12, Data2=34, Ready=1, Phase=10, Error=0.
REQ-029 SHALL cover: KeyValid held high 10 cycles with KeyCode=7 in ENTER_A -> Data1=7 exactly once.
REQ-030 SHALL cover: keys 2,5,6 in ENTER_A -> Error=1 and Data1=255 with the macro, Data1=0 without it; a following key 9 -> no change (MAX_DIGITS=3).
REQ-031 SHALL cover: keys 9,9,9,9,Enter -> Data1=255 with the macro (231 without it) and Error=1; the fourth 9 ignored, Phase=01.
REQ-032 SHALL cover: in DONE with Data1=12, Data2=34, key 5 -> Data1=5, Data2=0, Ready=0, Phase=00; Cancel mid-entry -> all zero.
REQ-033 SHALL cover: Clear low for 1 cycle during ENTER_B with KeyValid held high -> all outputs 0 immediately; no event after release until KeyValid falls and rises again.
